// File: rtl/kp_time_entry_if.sv
// Keypad time-entry bus.
//   key_code              : raw keypad code into the controller (0 = released)
//   now_h/now_m/now_s     : committed wall-clock time
//   now_set               : 1-cycle strobe when now_* is committed
//   alarm_h/alarm_m/alarm_s: packed alarm times, slot k at [5k+:5] / [6k+:6]
//   alarm_en              : per-slot enable
//   sel, digit_pos, busy, err : editor status
// slave  = controller side, master = keypad/host side.
interface kp_time_entry_if #(
  parameter int N_ALARM = 2,
  parameter int KEY_W   = 6
);
  localparam int SW = $clog2(N_ALARM + 1);

  logic [KEY_W-1:0]     key_code;
  logic [4:0]           now_h;
  logic [5:0]           now_m;
  logic [5:0]           now_s;
  logic                 now_set;
  logic [5*N_ALARM-1:0] alarm_h;
  logic [6*N_ALARM-1:0] alarm_m;
  logic [6*N_ALARM-1:0] alarm_s;
  logic [N_ALARM-1:0]   alarm_en;
  logic [SW-1:0]        sel;
  logic [2:0]           digit_pos;
  logic                 busy;
  logic                 err;

  modport slave (
    input  key_code,
    output now_h, now_m, now_s, now_set,
    output alarm_h, alarm_m, alarm_s, alarm_en,
    output sel, digit_pos, busy, err
  );

  modport master (
    output key_code,
    input  now_h, now_m, now_s, now_set,
    input  alarm_h, alarm_m, alarm_s, alarm_en,
    input  sel, digit_pos, busy, err
  );
endinterface

// File: rtl/kp_time_entry.sv
// Keypad-driven time-entry controller.
// Edits the wall clock (HH:MM or HH:MM:SS) and N_ALARM alarm slots from a 4x4
// keypad. Each key press (released -> nonzero) produces exactly one event.
// Digits are validated per position; SHIFT is backspace, AD aborts, ENTER
// commits. Committed values change only on ENTER, the RESET key or rst_n.
// Ports:
//   mclk  : system clock
//   rst_n : asynchronous active-low reset
//   bus   : kp_time_entry_if.slave (key input, committed times, status)
module kp_time_entry #(
  parameter int N_ALARM  = 2,
  parameter int WITH_SEC = 0,
  parameter int KEY_W    = 6
) (
  input  logic             mclk,
  input  logic             rst_n,
  kp_time_entry_if.slave   bus
);
  localparam int D  = (WITH_SEC != 0) ? 6 : 4;
  localparam int SW = $clog2(N_ALARM + 1);

  localparam logic [KEY_W-1:0] K_RESET = KEY_W'(1);
  localparam logic [KEY_W-1:0] K_CLOCK = KEY_W'(2);
  localparam logic [KEY_W-1:0] K_ENTER = KEY_W'(3);
  localparam logic [KEY_W-1:0] K_SHIFT = KEY_W'(4);
  localparam logic [KEY_W-1:0] K_ABORT = KEY_W'(8);

  typedef enum logic [1:0] {IDLE, ENTRY, CONFIRM} state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] value;
  } digit_t;

  // Keypad matrix position -> decimal digit.
  function automatic digit_t decode_digit(input logic [KEY_W-1:0] k);
    digit_t r;
    r.valid = 1'b1;
    case (k)
      KEY_W'(16): r.value = 4'd0;
      KEY_W'(15): r.value = 4'd1;
      KEY_W'(11): r.value = 4'd2;
      KEY_W'(7):  r.value = 4'd3;
      KEY_W'(14): r.value = 4'd4;
      KEY_W'(10): r.value = 4'd5;
      KEY_W'(6):  r.value = 4'd6;
      KEY_W'(13): r.value = 4'd7;
      KEY_W'(9):  r.value = 4'd8;
      KEY_W'(5):  r.value = 4'd9;
      default: begin
        r.valid = 1'b0;
        r.value = 4'd0;
      end
    endcase
    return r;
  endfunction

  // Range rule for digit d at position pos; h1 is the hour tens digit.
  function automatic logic digit_ok(input logic [2:0] pos, input logic [3:0] d,
                                    input logic [3:0] h1);
    case (pos)
      3'd0:       return d <= 4'd2;
      3'd1:       return (h1 != 4'd2) || (d <= 4'd3);
      3'd2, 3'd4: return d <= 4'd5;
      default:    return 1'b1;
    endcase
  endfunction

  state_t               state_q, state_d;
  logic [KEY_W-1:0]     key_q;
  logic [3:0]           dig_q [6];
  logic [3:0]           dig_d [6];
  logic [2:0]           pos_q, pos_d;
  logic [SW-1:0]        sel_q, sel_d;
  logic [4:0]           now_h_q, now_h_d;
  logic [5:0]           now_m_q, now_m_d;
  logic [5:0]           now_s_q, now_s_d;
  logic                 now_set_q, now_set_d;
  logic                 err_q, err_d;
  logic [5*N_ALARM-1:0] al_h_q, al_h_d;
  logic [6*N_ALARM-1:0] al_m_q, al_m_d;
  logic [6*N_ALARM-1:0] al_s_q, al_s_d;
  logic [N_ALARM-1:0]   al_en_q, al_en_d;

  logic   press;
  digit_t dkey;
  logic [4:0] hh;
  logic [5:0] mm, ss;

  assign press = (key_q == '0) && (bus.key_code != '0);
  assign dkey  = decode_digit(bus.key_code);

  // Buffer -> binary fields; position rules keep these within range.
  assign hh = 5'(dig_q[0]) * 5'd10 + 5'(dig_q[1]);
  assign mm = 6'(dig_q[2]) * 6'd10 + 6'(dig_q[3]);
  assign ss = (WITH_SEC != 0) ? 6'(dig_q[4]) * 6'd10 + 6'(dig_q[5]) : 6'd0;

  // NOTE: every variable gets its hold/default value before any branch, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    sel_d     = sel_q;
    dig_d     = dig_q;
    now_h_d   = now_h_q;
    now_m_d   = now_m_q;
    now_s_d   = now_s_q;
    al_h_d    = al_h_q;
    al_m_d    = al_m_q;
    al_s_d    = al_s_q;
    al_en_d   = al_en_q;
    now_set_d = 1'b0;
    err_d     = 1'b0;

    if (press) begin
      if (bus.key_code == K_RESET) begin
        state_d = IDLE;
        pos_d   = '0;
        sel_d   = '0;
        dig_d   = '{default: '0};
        now_h_d = '0;
        now_m_d = '0;
        now_s_d = '0;
        al_h_d  = '0;
        al_m_d  = '0;
        al_s_d  = '0;
        al_en_d = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.key_code == K_CLOCK) begin
              sel_d = (sel_q == SW'(N_ALARM)) ? '0 : sel_q + 1'b1;
            end else if (dkey.valid) begin
              dig_d = '{default: '0};
              if (digit_ok(3'd0, dkey.value, 4'd0)) begin
                dig_d[0] = dkey.value;
                pos_d    = 3'd1;
                state_d  = ENTRY;
              end else begin
                err_d = 1'b1;
              end
            end else if (bus.key_code == K_ENTER) begin
              for (int k = 0; k < N_ALARM; k++)
                if (sel_q == SW'(k + 1)) al_en_d[k] = ~al_en_q[k];
            end
          end

          ENTRY: begin
            if (dkey.valid) begin
              if (digit_ok(pos_q, dkey.value, dig_q[0])) begin
                for (int i = 0; i < 6; i++)
                  if (pos_q == 3'(i)) dig_d[i] = dkey.value;
                pos_d = pos_q + 1'b1;
                if (pos_q == 3'(D - 1)) state_d = CONFIRM;
              end else begin
                err_d = 1'b1;
              end
            end else if (bus.key_code == K_SHIFT) begin
              if (pos_q == '0) begin
                state_d = IDLE;
              end else begin
                pos_d = pos_q - 1'b1;
                for (int i = 0; i < 6; i++)
                  if (pos_q == 3'(i + 1)) dig_d[i] = '0;
              end
            end else if (bus.key_code == K_ABORT) begin
              state_d = IDLE;
              pos_d   = '0;
              dig_d   = '{default: '0};
            end
          end

          CONFIRM: begin
            if (dkey.valid) begin
              err_d = 1'b1;
            end else if (bus.key_code == K_SHIFT) begin
              state_d      = ENTRY;
              pos_d        = 3'(D - 1);
              dig_d[D - 1] = '0;
            end else if (bus.key_code == K_ABORT) begin
              state_d = IDLE;
              pos_d   = '0;
              dig_d   = '{default: '0};
            end else if (bus.key_code == K_ENTER) begin
              state_d = IDLE;
              pos_d   = '0;
              if (sel_q == '0) begin
                now_h_d   = hh;
                now_m_d   = mm;
                now_s_d   = ss;
                now_set_d = 1'b1;
              end else begin
                for (int k = 0; k < N_ALARM; k++) begin
                  if (sel_q == SW'(k + 1)) begin
                    al_h_d[5*k +: 5] = hh;
                    al_m_d[6*k +: 6] = mm;
                    al_s_d[6*k +: 6] = ss;
                    al_en_d[k]       = 1'b1;
                  end
                end
              end
            end
          end

          default: state_d = IDLE;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      key_q     <= '1;  // a key held through reset release is not a press
      pos_q     <= '0;
      sel_q     <= '0;
      // NOTE: the small digit buffer is reset with everything else; it is six
      // registers, not a RAM, and a clean start keeps commits deterministic.
      dig_q     <= '{default: '0};
      now_h_q   <= '0;
      now_m_q   <= '0;
      now_s_q   <= '0;
      now_set_q <= 1'b0;
      err_q     <= 1'b0;
      al_h_q    <= '0;
      al_m_q    <= '0;
      al_s_q    <= '0;
      al_en_q   <= '0;
    end else begin
      state_q   <= state_d;
      key_q     <= bus.key_code;
      pos_q     <= pos_d;
      sel_q     <= sel_d;
      dig_q     <= dig_d;
      now_h_q   <= now_h_d;
      now_m_q   <= now_m_d;
      now_s_q   <= now_s_d;
      now_set_q <= now_set_d;
      err_q     <= err_d;
      al_h_q    <= al_h_d;
      al_m_q    <= al_m_d;
      al_s_q    <= al_s_d;
      al_en_q   <= al_en_d;
    end
  end

  assign bus.now_h     = now_h_q;
  assign bus.now_m     = now_m_q;
  assign bus.now_s     = now_s_q;
  assign bus.now_set   = now_set_q;
  assign bus.alarm_h   = al_h_q;
  assign bus.alarm_m   = al_m_q;
  assign bus.alarm_s   = al_s_q;
  assign bus.alarm_en  = al_en_q;
  assign bus.sel       = sel_q;
  assign bus.digit_pos = pos_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.err       = err_q;
endmodule

// File: tb/tb_kp_time_entry.sv
// Bench for kp_time_entry: an HH:MM build (inst 0) and an HH:MM:SS build
// (inst 1) receive the same key stream and are compared every cycle against a
// digit-list reference model; directed tables cover the keypad scenarios.
module tb_kp_time_entry;
  localparam int NA = 2;

  logic mclk = 1'b0;
  logic rst_n;
  always #5 mclk = ~mclk;

  kp_time_entry_if #(.N_ALARM(NA), .KEY_W(6)) bus0 ();
  kp_time_entry_if #(.N_ALARM(NA), .KEY_W(6)) bus1 ();

  kp_time_entry #(.N_ALARM(NA), .WITH_SEC(0), .KEY_W(6)) dut0 (
    .mclk(mclk), .rst_n(rst_n), .bus(bus0));
  kp_time_entry #(.N_ALARM(NA), .WITH_SEC(1), .KEY_W(6)) dut1 (
    .mclk(mclk), .rst_n(rst_n), .bus(bus1));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // An edit is a list of typed digits (m_dig[0..m_n-1]); it is complete when
  // the list holds D digits. busy means an edit is open.
  int m_dig [2][6];
  int m_n [2];
  bit m_busy [2];
  int m_sel [2];
  int m_now [2][3];
  int m_al [2][NA][3];
  bit m_en [2][NA];
  bit m_nowset [2];
  bit m_err [2];
  int m_prev [2];

  function automatic int dlen(input int i);
    return (i == 0) ? 4 : 6;
  endfunction

  function automatic int digit_of(input int key);
    int dk [10] = '{16, 15, 11, 7, 14, 10, 6, 13, 9, 5};
    for (int j = 0; j < 10; j++) if (dk[j] == key) return j;
    return -1;
  endfunction

  // Each field pair (hours, minutes, seconds) must stay below its limit.
  function automatic bit accept(input int i, input int n, input int d);
    int lim [3] = '{24, 60, 60};
    if (n % 2 == 0) return d * 10 < lim[n / 2];
    return m_dig[i][n - 1] * 10 + d < lim[n / 2];
  endfunction

  task automatic model_clear(input int i);
    m_busy[i] = 0; m_n[i] = 0; m_sel[i] = 0;
    m_nowset[i] = 0; m_err[i] = 0;
    for (int f = 0; f < 3; f++) m_now[i][f] = 0;
    for (int k = 0; k < NA; k++) begin
      m_en[i][k] = 0;
      for (int f = 0; f < 3; f++) m_al[i][k][f] = 0;
    end
  endtask

  task automatic model_step(input int i, input int key);
    int d, v[3];
    bit p;
    m_nowset[i] = 0;
    m_err[i] = 0;
    p = (m_prev[i] == 0) && (key != 0);
    m_prev[i] = key;
    if (!p) return;
    d = digit_of(key);
    if (key == 1) begin
      model_clear(i);
    end else if (!m_busy[i]) begin
      if (key == 2) m_sel[i] = (m_sel[i] + 1) % (NA + 1);
      else if (d >= 0) begin
        m_n[i] = 0;
        if (accept(i, 0, d)) begin
          m_dig[i][0] = d; m_n[i] = 1; m_busy[i] = 1;
        end else m_err[i] = 1;
      end else if (key == 3 && m_sel[i] > 0) m_en[i][m_sel[i] - 1] ^= 1'b1;
    end else if (d >= 0) begin
      if (m_n[i] < dlen(i) && accept(i, m_n[i], d)) begin
        m_dig[i][m_n[i]] = d; m_n[i]++;
      end else m_err[i] = 1;
    end else if (key == 4) begin
      if (m_n[i] == 0) m_busy[i] = 0;
      else m_n[i]--;
    end else if (key == 8) begin
      m_busy[i] = 0; m_n[i] = 0;
    end else if (key == 3 && m_n[i] == dlen(i)) begin
      v[0] = m_dig[i][0] * 10 + m_dig[i][1];
      v[1] = m_dig[i][2] * 10 + m_dig[i][3];
      v[2] = (dlen(i) == 6) ? m_dig[i][4] * 10 + m_dig[i][5] : 0;
      if (m_sel[i] == 0) begin
        for (int f = 0; f < 3; f++) m_now[i][f] = v[f];
        m_nowset[i] = 1;
      end else begin
        for (int f = 0; f < 3; f++) m_al[i][m_sel[i] - 1][f] = v[f];
        m_en[i][m_sel[i] - 1] = 1;
      end
      m_busy[i] = 0; m_n[i] = 0;
    end
  endtask

  task automatic cmp(input int i, input string tag);
    logic [63:0] a_ctl, e_ctl, a_al, e_al;
    logic [5*NA-1:0] eh;
    logic [6*NA-1:0] em, es;
    logic [NA-1:0] een;
    for (int k = 0; k < NA; k++) begin
      eh[5*k +: 5] = 5'(m_al[i][k][0]);
      em[6*k +: 6] = 6'(m_al[i][k][1]);
      es[6*k +: 6] = 6'(m_al[i][k][2]);
      een[k] = m_en[i][k];
    end
    e_ctl = 64'({5'(m_now[i][0]), 6'(m_now[i][1]), 6'(m_now[i][2]), m_nowset[i],
                 m_err[i], m_busy[i], 3'(m_n[i]), 2'(m_sel[i]), een});
    e_al = 64'({eh, em, es});
    if (i == 0) begin
      a_ctl = 64'({bus0.now_h, bus0.now_m, bus0.now_s, bus0.now_set, bus0.err,
                   bus0.busy, bus0.digit_pos, bus0.sel, bus0.alarm_en});
      a_al = 64'({bus0.alarm_h, bus0.alarm_m, bus0.alarm_s});
    end else begin
      a_ctl = 64'({bus1.now_h, bus1.now_m, bus1.now_s, bus1.now_set, bus1.err,
                   bus1.busy, bus1.digit_pos, bus1.sel, bus1.alarm_en});
      a_al = 64'({bus1.alarm_h, bus1.alarm_m, bus1.alarm_s});
    end
    check($sformatf("%s inst%0d ctl", tag, i), a_ctl, e_ctl);
    check($sformatf("%s inst%0d alarm", tag, i), a_al, e_al);
  endtask

  // One clock with key applied to both builds; compare after the edge.
  task automatic step(input int key, input string tag = "step");
    model_step(0, key);
    model_step(1, key);
    bus0.key_code = 6'(key);
    bus1.key_code = 6'(key);
    @(posedge mclk);
    #1;
    cmp(0, tag);
    cmp(1, tag);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      model_clear(i);
      m_prev[i] = -1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge mclk);
    #1;
    cmp(0, "reset");
    cmp(1, "reset");
    rst_n = 1'b1;
  endtask

  // ---------------- directed table (inst 0, HH:MM) ----------------
  typedef struct {
    int key;
    int pos;
    bit busy;
    bit err;
    bit nset;
    int sel;
    int nh;
    int nm;
    int en;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int key, pos, input bit busy, err, nset,
                     input int sel, nh, nm, en);
    vec_t v;
    v.key = key; v.pos = pos; v.busy = busy; v.err = err; v.nset = nset;
    v.sel = sel; v.nh = nh; v.nm = nm; v.en = en;
    tbl.push_back(v);
  endtask

  initial begin
    int key, pool[17];
    pool = '{2, 3, 3, 4, 8, 12, 20, 16, 15, 11, 7, 14, 10, 6, 13, 9, 5};
    rst_n = 1'b0;
    bus0.key_code = '0;
    bus1.key_code = '0;
    #2;
    apply_reset();
    check("reset_all_zero", 64'({bus0.now_h, bus0.now_m, bus0.now_s, bus0.now_set,
          bus0.alarm_h, bus0.alarm_en, bus0.sel, bus0.digit_pos, bus0.busy, bus0.err}), 64'd0);
    step(0);

    // 23:59 commit
    add(11,1,1,0,0,0,0,0,0); add(0,1,1,0,0,0,0,0,0);
    add(7,2,1,0,0,0,0,0,0);  add(0,2,1,0,0,0,0,0,0);
    add(10,3,1,0,0,0,0,0,0); add(0,3,1,0,0,0,0,0,0);
    add(5,4,1,0,0,0,0,0,0);  add(0,4,1,0,0,0,0,0,0);
    add(3,0,0,0,1,0,23,59,0); add(0,0,0,0,0,0,23,59,0);
    // 2 then 4 rejected, 3 accepted, abort
    add(11,1,1,0,0,0,23,59,0); add(0,1,1,0,0,0,23,59,0);
    add(14,1,1,1,0,0,23,59,0); add(0,1,1,0,0,0,23,59,0);
    add(7,2,1,0,0,0,23,59,0);  add(0,2,1,0,0,0,23,59,0);
    add(8,0,0,0,0,0,23,59,0);  add(0,0,0,0,0,0,23,59,0);
    // alarm slot 0 = 07:30, then toggle enable off, cycle sel back to 0
    add(2,0,0,0,0,1,23,59,0);  add(0,0,0,0,0,1,23,59,0);
    add(16,1,1,0,0,1,23,59,0); add(0,1,1,0,0,1,23,59,0);
    add(13,2,1,0,0,1,23,59,0); add(0,2,1,0,0,1,23,59,0);
    add(7,3,1,0,0,1,23,59,0);  add(0,3,1,0,0,1,23,59,0);
    add(16,4,1,0,0,1,23,59,0); add(0,4,1,0,0,1,23,59,0);
    add(3,0,0,0,0,1,23,59,1);  add(0,0,0,0,0,1,23,59,1);
    add(3,0,0,0,0,1,23,59,0);  add(0,0,0,0,0,1,23,59,0);
    add(2,0,0,0,0,2,23,59,0);  add(0,0,0,0,0,2,23,59,0);
    add(2,0,0,0,0,0,23,59,0);  add(0,0,0,0,0,0,23,59,0);
    // backspace to idle
    add(15,1,1,0,0,0,23,59,0); add(0,1,1,0,0,0,23,59,0);
    add(11,2,1,0,0,0,23,59,0); add(0,2,1,0,0,0,23,59,0);
    add(4,1,1,0,0,0,23,59,0);  add(0,1,1,0,0,0,23,59,0);
    add(4,0,1,0,0,0,23,59,0);  add(0,0,1,0,0,0,23,59,0);
    add(4,0,0,0,0,0,23,59,0);  add(0,0,0,0,0,0,23,59,0);
    // held key gives one event; nonzero->nonzero change is not a press
    for (int r = 0; r < 10; r++) add(15,1,1,0,0,0,23,59,0);
    add(16,1,1,0,0,0,23,59,0); add(0,1,1,0,0,0,23,59,0);
    add(16,2,1,0,0,0,23,59,0); add(0,2,1,0,0,0,23,59,0);
    add(8,0,0,0,0,0,23,59,0);  add(0,0,0,0,0,0,23,59,0);

    foreach (tbl[i]) begin
      step(tbl[i].key, "tbl");
      check($sformatf("tbl[%0d] key=%0d", i, tbl[i].key),
            64'({bus0.digit_pos, bus0.busy, bus0.err, bus0.now_set, bus0.sel,
                 bus0.now_h, bus0.now_m, bus0.alarm_en}),
            64'({3'(tbl[i].pos), tbl[i].busy, tbl[i].err, tbl[i].nset, 2'(tbl[i].sel),
                 5'(tbl[i].nh), 6'(tbl[i].nm), 2'(tbl[i].en)}));
    end
    check("slot0_time", 64'({bus0.alarm_h[4:0], bus0.alarm_m[5:0], bus0.alarm_s[5:0]}),
          64'({5'd7, 6'd30, 6'd0}));

    // rst_n mid-entry with key 15 held
    step(15);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    cmp(0, "async_rst");
    check("async_rst_pos", 64'({bus0.digit_pos, bus0.busy, bus0.now_h}), 64'd0);
    @(posedge mclk);
    #1 rst_n = 1'b1;
    repeat (3) step(15, "held_after_rst");
    check("held_no_press", 64'({bus0.busy, bus0.digit_pos}), 64'd0);
    step(0);
    step(15);
    check("press_after_release", 64'({bus0.busy, bus0.digit_pos}), 64'({1'b1, 3'd1}));
    // RESET key clears everything, held key gives no further event
    step(0); step(1, "reset_key"); step(1); step(1);
    check("reset_key_clear", 64'({bus0.busy, bus0.digit_pos, bus0.now_h, bus0.now_m}), 64'd0);
    step(0);

    // seconds build: 23:5x with S1=6 rejected, then 23:59:58
    apply_reset();
    step(0);
    foreach (pool[j]) if (j < 0) step(pool[j]);
    step(11); step(0); step(7); step(0); step(10); step(0); step(5); step(0);
    step(6, "s1_six");
    check("sec_s1_reject", 64'({bus1.err, bus1.digit_pos, bus0.err, bus0.digit_pos}),
          64'({1'b1, 3'd4, 1'b1, 3'd4}));
    step(0); step(10); step(0); step(9); step(0);
    check("sec_confirm_pos", 64'(bus1.digit_pos), 64'd6);
    step(3, "sec_commit");
    check("sec_commit", 64'({bus1.now_set, bus1.now_h, bus1.now_m, bus1.now_s}),
          64'({1'b1, 5'd23, 6'd59, 6'd58}));
    check("min_commit", 64'({bus0.now_set, bus0.now_h, bus0.now_m, bus0.now_s}),
          64'({1'b1, 5'd23, 6'd59, 6'd0}));
    step(0);

    // randomized stream against the model
    key = 0;
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom_range(0, 299));
      if (r < 1) key = 1;
      else if (r < 80) key = key;
      else if (r < 200) key = 0;
      else key = pool[$urandom_range(0, 16)];
      step(key, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
